// File: rtl/rotary_encoder_decoder.sv
// Front-panel rotary encoder front end: synchronise, debounce and quadrature-decode
// the encoder lines into the 8-bit register read over SPI (cleared on each read).
module rotary_encoder_decoder #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DETENT_STEPS    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       encoder_A,
  input  logic       encoder_B,
  input  logic       encoder_sw,
  input  logic       rotary_encoder_rd_stb,
  output logic [7:0] rotary_encoder_reg,
  output logic       quad_error
);

  localparam logic [15:0]        DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [3:0]  ACC_MAX  = 4'(DETENT_STEPS);
  localparam logic signed [3:0]  ACC_MIN  = -ACC_MAX;
  localparam logic signed [6:0]  CNT_HI   = 7'sd31;
  localparam logic signed [6:0]  CNT_LO   = -7'sd32;

  function automatic logic signed [5:0] sat_add(input logic signed [5:0] a,
                                                input logic signed [1:0] d);
    logic signed [6:0] s;
    s = {a[5], a} + {{5{d[1]}}, d};
    if (s > CNT_HI)      sat_add = 6'b011111;
    else if (s < CNT_LO) sat_add = 6'b100000;
    else                 sat_add = s[5:0];
  endfunction

  logic [2:0]        sync_p0, sync_p1, deb_p2;
  logic [15:0]       db_cnt [3];
  logic [1:0]        prev_ab_p3;
  logic signed [3:0] acc_p3;

  logic signed [3:0] step, acc_sum, acc_nxt;
  logic signed [1:0] detent;
  logic              bad_step, press_edge;

  // Stage p0/p1: two-flop synchronisers, bit order {sw, A, B}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {encoder_sw, encoder_A, encoder_B};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-line debounce counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_p2 <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb_p2[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    step = '0;
    case ({prev_ab_p3, deb_p2[1:0]})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step = 4'sd1;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: step = -4'sd1;
      default:                            step = '0;
    endcase
    bad_step = &(prev_ab_p3 ^ deb_p2[1:0]);
    acc_sum  = acc_p3 + step;
    detent   = '0;
    acc_nxt  = acc_sum;
    if (acc_sum == ACC_MAX) begin
      detent  = 2'sb01;
      acc_nxt = '0;
    end else if (acc_sum == ACC_MIN) begin
      detent  = 2'sb11;
      acc_nxt = '0;
    end
    // Bit 7 holds last cycle's debounced switch, so it doubles as the edge history.
    press_edge = deb_p2[2] & ~rotary_encoder_reg[7];
  end

  // Stage p3: decode state and the SPI-visible register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ab_p3         <= '0;
      acc_p3             <= '0;
      quad_error         <= 1'b0;
      rotary_encoder_reg <= '0;
    end else begin
      prev_ab_p3            <= deb_p2[1:0];
      acc_p3                <= acc_nxt;
      quad_error            <= bad_step;
      rotary_encoder_reg[7] <= deb_p2[2];
      if (rotary_encoder_rd_stb) begin
        rotary_encoder_reg[6]   <= press_edge;
        rotary_encoder_reg[5:0] <= {{4{detent[1]}}, detent};
      end else begin
        rotary_encoder_reg[6]   <= rotary_encoder_reg[6] | press_edge;
        rotary_encoder_reg[5:0] <= sat_add(rotary_encoder_reg[5:0], detent);
      end
    end
  end

endmodule

// File: doc/rotary_encoder_decoder.md
# rotary_encoder_decoder

Front-panel rotary-encoder front end that synchronises, debounces and quadrature-decodes the encoder A/B/switch lines into the 8-bit rotary encoder register read by the SPI register interface. It sits directly upstream of the SPI register interface and replaces the raw encoder handling in the front panel. The register holds a signed detent delta and switch state. It is cleared on each SPI read strobe, so software sees the motion since its last read.

## Interface
- DEBOUNCE_CYCLES, 1000: consecutive stable `clk` cycles required before a debounced input changes; legal range 2..65535.
- DETENT_STEPS, 4: quadrature quarter-steps per reported detent; legal values 1, 2, 4.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- encoder_A  in  1  raw encoder phase A, asynchronous.
- encoder_B  in  1  raw encoder phase B, asynchronous.
- encoder_sw  in  1  raw push switch, active-high = pressed, asynchronous.
- rotary_encoder_rd_stb  in  1  single-`clk` pulse issued when SPI reads the register.
- rotary_encoder_reg  out  8  [7] debounced switch level; [6] press event, sticky; [5:0] signed two's-complement detent delta.
- quad_error  out  1  one-cycle pulse when both debounced phases change in the same cycle.

## Operation
- **Synchroniser:** each raw input passes through a 2-FF synchroniser. Synchroniser flops reset to 0.
- **Debounce:** each input has its own counter (16 bits).
  - Counter clears whenever the synced value equals the debounced value.
  - Counter increments while the two differ.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced value takes the synced value and the counter clears.
  - Debounced values reset to 0.
- **Quadrature decode:** compares the previous debounced {A,B} with the current value.
  - Forward (CW) sequence is 00→01→11→10→00; reverse is the opposite.
  - A valid forward step adds +1 to a signed quarter-step accumulator; a valid reverse step adds -1.
  - If both bits change in one cycle, pulse quad_error. The accumulator is unchanged and the previous state takes the new value.
  - When the accumulator reaches +DETENT_STEPS, emit detent +1 and clear it. When it reaches -DETENT_STEPS, emit detent -1 and clear it.
- **Delta count:** bits [5:0] add the detent, saturating at +31 (6'h1F) and -32 (6'h20). Saturation never wraps.
- **Press event:** bit [6] sets on the debounced switch rising edge and stays set until cleared by a read.
- **Switch level:** bit [7] equals the registered debounced switch level.
- **Read clear:** on rotary_encoder_rd_stb, bits [6:0] clear.
  - If a detent occurs in the same cycle, the count becomes that detent (+1 or -1), not 0.
  - If a press edge occurs in the same cycle, bit [6] ends up 1.
  - Bit [7] is never cleared by a read.
- **Reset:** asserting reset at any time, including mid-debounce or mid-detent, clears all state. rotary_encoder_reg = 8'h00, quad_error = 0, accumulator = 0, all debounce counters = 0.

## Timing
- An input transition first sampled by synchroniser stage 1 at edge 0, and stable from then on, reaches the synced value at edge 2.
- The debounced value changes at edge 2+DEBOUNCE_CYCLES.
- rotary_encoder_reg and quad_error reflect the change at edge 3+DEBOUNCE_CYCLES.
- Input glitches shorter than DEBOUNCE_CYCLES cycles, measured at the synced value, produce no change.
- Read clear takes effect at the `clk` edge where rd_stb is sampled high. The register shows the cleared or updated value from the next cycle.
- At most one detent per cycle. Throughput is bounded by the debounce time, not by the decode logic.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
1. **Reset values.** DEBOUNCE_CYCLES=4, DETENT_STEPS=4. Assert reset mid-operation → reg=8'h00 and quad_error=0 immediately, with no clock edge required. Release reset → outputs stay 0 with idle inputs.
2. **CW then CCW detents.**
   - Drive 3 full CW cycles (00→01→11→10→00), each state held 10 cycles → reg[5:0]=6'h03.
   - Then drive 5 CCW cycles → reg[5:0]=6'h3E (-2).
   - Check that each detent appears exactly 3+DEBOUNCE_CYCLES cycles after the closing 00 input.
3. **Debounce and glitch rejection.**
   - 3-cycle glitch on encoder_A → no count and no quad_error.
   - encoder_sw held high for 20 cycles → reg=8'hC0.
   - Pulse rd_stb → reg=8'h80.
   - Release the switch → reg=8'h00.
4. **Saturation.** Drive 40 CW detents → reg[5:0]=6'h1F. Read, then drive 40 CCW detents → reg[5:0]=6'h20, with no wrap in either direction.
5. **Read/event collision.** Time rd_stb to coincide with a CW detent while the count is 6'h05 → next cycle reg[5:0]=6'h01. Time rd_stb to coincide with a switch rising edge → bit[6]=1.
6. **Invalid transition.** Change A and B together (00→11) → one-cycle quad_error pulse and count unchanged. The subsequent valid sequence from 11 decodes correctly.
